// File: rtl/mips_pkg.sv
// Shared types for the memory-port arbiter: FSM state and grant owner.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_LS = 1'b1
    } grant_t;

    // Latency counter width; covers MEM_LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Access latency counter: cleared on load, counts while enabled, flags the
// final cycle of an access (count == MEM_LATENCY-1).
module mem_lat_counter
    import mips_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Clear on reset or load, otherwise advance once per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(MEM_LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between instruction fetch and load/store.
// Each access occupies the port for MEM_LATENCY cycles; the owner's ready
// pulses one cycle after the access ends.
// Optional feature: define MEM_ARB_RR_EN for round-robin contention
// resolution; otherwise load/store has fixed priority.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            halted,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_ready,
    output logic [XLEN-1:0] ls_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_data_in  [4],
    input  logic [7:0]      mem_data_out [4],
    output logic            mem_write_en
);

    arb_state_t      state_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            we_q;
    logic            if_ready_q;
    logic            ls_ready_q;
    logic [XLEN-1:0] if_rdata_q;
    logic [XLEN-1:0] ls_rdata_q;
`ifdef MEM_ARB_RR_EN
    grant_t          last_grant_q;
`endif

    logic            if_vld;
    logic            ls_vld;
    logic            accept;
    logic            busy;
    logic            tc;
    grant_t          grant_d;
    logic [31:0]     rd_word;
    logic [31:0]     wd_word;

    // A requester whose ready is pulsing this cycle is still finishing the
    // previous access, so it is not a new request yet.
    assign if_vld  = if_req && !if_ready_q;
    assign ls_vld  = ls_req && !ls_ready_q;
    assign accept  = (state_q == IDLE) && !halted && (if_vld || ls_vld);
    assign busy    = (state_q != IDLE);
    assign rd_word = {mem_data_out[0], mem_data_out[1], mem_data_out[2], mem_data_out[3]};
    assign wd_word = wdata_q[31:0];

    // Pick the owner of the next access among valid requesters.
    always_comb begin
        grant_d = GNT_IF;
`ifdef MEM_ARB_RR_EN
        if (if_vld && ls_vld) begin
            grant_d = (last_grant_q == GNT_LS) ? GNT_IF : GNT_LS;
        end else if (ls_vld) begin
            grant_d = GNT_LS;
        end
`else
        if (ls_vld) begin
            grant_d = GNT_LS;
        end
`endif
    end

    mem_lat_counter #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_lat (
        .clk   (clk),
        .rst_b (rst_b),
        .load_i(accept),
        .en_i  (busy),
        .tc_o  (tc)
    );

    // Arbitration FSM: latch the granted request, wait out the latency,
    // then capture read data and pulse the owner's ready.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            if_ready_q   <= 1'b0;
            ls_ready_q   <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= GNT_IF;
`endif
        end else begin
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (grant_d == GNT_LS) begin
                            addr_q  <= ls_addr;
                            wdata_q <= ls_wdata;
                            we_q    <= ls_we;
                            state_q <= LS_BUSY;
                        end else begin
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            we_q    <= 1'b0;
                            state_q <= IF_BUSY;
                        end
`ifdef MEM_ARB_RR_EN
                        last_grant_q <= grant_d;
`endif
                    end
                end
                IF_BUSY: begin
                    if (tc) begin
                        if_rdata_q <= XLEN'(rd_word);
                        if_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                LS_BUSY: begin
                    if (tc) begin
                        if (!we_q) begin
                            ls_rdata_q <= XLEN'(rd_word);
                        end
                        ls_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Store bytes go out most-significant first.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_data_in[i] = wd_word[31-8*i -: 8];
        end
    end

    assign mem_write_en = (state_q == LS_BUSY) && tc && we_q;
    assign mem_addr     = addr_q;
    assign if_ready     = if_ready_q;
    assign ls_ready     = ls_ready_q;
    assign if_rdata     = if_rdata_q;
    assign ls_rdata     = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard.
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_b, halted;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_ready, ls_ready, mem_write_en;
    logic [31:0] if_rdata, ls_rdata, mem_addr;
    logic [7:0]  mdi [4];
    logic [7:0]  mdo [4];

    always #5 clk = ~clk;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(L)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .halted      (halted),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_ready    (ls_ready),
        .ls_rdata    (ls_rdata),
        .mem_addr    (mem_addr),
        .mem_data_in (mdi),
        .mem_data_out(mdo),
        .mem_write_en(mem_write_en)
    );

    typedef struct packed {
        logic        is_ls;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          we_cyc = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] b [4]);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic set_mdo(input logic [31:0] w);
        mdo[0] = w[31:24];
        mdo[1] = w[23:16];
        mdo[2] = w[15:8];
        mdo[3] = w[7:0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until a ready pulse is visible; returns the number of edges taken.
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (1) begin
            step();
            n++;
            if (if_ready || ls_ready) break;
            if (n >= 20) break;
        end
        if (!(if_ready || ls_ready)) chk({tag, "_timeout"}, 32'(n), 32'(L));
    endtask

    // Monitor: record write strobes, retire scoreboard entries on ready.
    always @(negedge clk) begin
        if (rst_b) begin
            if (mem_write_en) begin
                we_cnt++;
                we_cyc  = cyc;
                we_addr = mem_addr;
                we_data = pk(mdi);
            end
            if (if_ready || ls_ready) begin
                chk("ready_exclusive", {31'b0, if_ready & ls_ready}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ready", {30'b0, if_ready, ls_ready}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_port", {31'b0, ls_ready}, {31'b0, e.is_ls});
                    chk("ready_rdata", e.is_ls ? ls_rdata : if_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        int          n;
        int          t0;
        int          we0;
        logic        order [3];
        logic [31:0] d;
        logic [31:0] ls_exp;

        rst_b = 1'b0; halted = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
        set_mdo(32'h0);
        step();
        step();
        chk("rst_if_ready", {31'b0, if_ready}, 32'd0);
        chk("rst_ls_ready", {31'b0, ls_ready}, 32'd0);
        chk("rst_write_en", {31'b0, mem_write_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_data_in", pk(mdi), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_b = 1'b1;
        step();

        // Fetch read.
        set_mdo(32'hDEADBEEF);
        if_addr = 32'h100; if_req = 1'b1;
        we0 = we_cnt;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        step();
        chk("fetch_addr", mem_addr, 32'h100);
        wait_ready("fetch", n);
        if_req = 1'b0;
        chk("fetch_latency", 32'(n + 1), 32'(L + 1));
        step();
        chk("fetch_ready_pulse", {31'b0, if_ready}, 32'd0);
        chk("fetch_rdata_held", if_rdata, 32'hDEADBEEF);
        chk("fetch_no_write", 32'(we_cnt), 32'(we0));

        // Store.
        set_mdo(32'hAABBCCDD);
        ls_addr = 32'h40; ls_wdata = 32'h12345678; ls_we = 1'b1; ls_req = 1'b1;
        we0 = we_cnt; t0 = cyc;
        sb.push_back('{1'b1, 32'h0});
        step();
        chk("store_addr", mem_addr, 32'h40);
        chk("store_data_in", pk(mdi), 32'h12345678);
        wait_ready("store", n);
        ls_req = 1'b0; ls_we = 1'b0;
        chk("store_latency", 32'(n + 1), 32'(L + 1));
        chk("store_we_count", 32'(we_cnt - we0), 32'd1);
        chk("store_we_cycle", 32'(we_cyc - t0), 32'(L));
        chk("store_we_addr", we_addr, 32'h40);
        chk("store_we_data", we_data, 32'h12345678);
        step();
        chk("store_ls_rdata_kept", ls_rdata, 32'h0);

        // Contention, starting from reset state.
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        step();
`ifdef MEM_ARB_RR_EN
        order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b1;
`else
        order[0] = 1'b1; order[1] = 1'b1; order[2] = 1'b1;
`endif
        if_addr = 32'h200; ls_addr = 32'h300; ls_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 32'h10203040 + 32'(k) * 32'h01010101;
            set_mdo(d);
            if_req = 1'b1; ls_req = 1'b1;
            sb.push_back('{order[k], d});
            step();
            chk("contend_grant_addr", mem_addr, order[k] ? 32'h300 : 32'h200);
            wait_ready("contend", n);
            if_req = 1'b0; ls_req = 1'b0;
            step();
        end
        ls_exp = order[2] ? 32'h12223242 : 32'h0;
        chk("contend_ls_rdata", ls_rdata, ls_exp);

        // Reset in the middle of a store.
        we0 = we_cnt;
        ls_addr = 32'h80; ls_wdata = 32'hCAFEF00D; ls_we = 1'b1; ls_req = 1'b1;
        step();
        step();
        rst_b = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        step();
        chk("abort_write_en", {31'b0, mem_write_en}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'h0);
        chk("abort_data_in", pk(mdi), 32'h0);
        chk("abort_ls_rdata", ls_rdata, 32'h0);
        rst_b = 1'b1;
        repeat (6) step();
        chk("abort_no_write", 32'(we_cnt), 32'(we0));
        chk("abort_addr_idle", mem_addr, 32'h0);

        // Halt raised during a fetch with load/store pending.
        set_mdo(32'h55667788);
        if_addr = 32'h500; if_req = 1'b1;
        sb.push_back('{1'b0, 32'h55667788});
        step();
        ls_addr = 32'h600; ls_we = 1'b0; ls_req = 1'b1; halted = 1'b1;
        wait_ready("halt_fetch", n);
        if_req = 1'b0;
        chk("halt_fetch_latency", 32'(n + 1), 32'(L + 1));
        repeat (5) step();
        chk("halt_blocks_grant", mem_addr, 32'h500);
        set_mdo(32'h99AABBCC);
        halted = 1'b0;
        sb.push_back('{1'b1, 32'h99AABBCC});
        step();
        chk("halt_release_grant", mem_addr, 32'h600);
        wait_ready("halt_ls", n);
        ls_req = 1'b0;
        chk("halt_ls_latency", 32'(n + 1), 32'(L + 1));
        step();

        // Fetch request held through its ready cycle.
        set_mdo(32'h0F0E0D0C);
        if_addr = 32'h700; if_req = 1'b1;
        sb.push_back('{1'b0, 32'h0F0E0D0C});
        sb.push_back('{1'b0, 32'h0F0E0D0C});
        wait_ready("held_first", n);
        chk("held_first_latency", 32'(n), 32'(L + 1));
        if_addr = 32'h704;
        step();
        chk("held_no_dup_grant", mem_addr, 32'h700);
        step();
        chk("held_regrant", mem_addr, 32'h704);
        wait_ready("held_second", n);
        if_req = 1'b0;
        chk("held_second_latency", 32'(n), 32'(L));
        repeat (3) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
